// File: rtl/scan_xfer_sched.sv
// Grants the shared downlink to one ready scanner at a time (round robin), tracks the
// transfer to completion or abort, then enforces a gap. Optional watchdog: XSCHED_WDOG_EN.
module scan_xfer_sched #(
  parameter int GAP_CYCLES  = 4,
  parameter int WDOG_CYCLES = 255,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             link_en,
  input  logic [2:0]       state1,
  input  logic [2:0]       state2,
  input  logic             rdy_xfer1,
  input  logic             rdy_xfer2,
  output logic             xfer1,
  output logic             xfer2,
  output logic             busy,
  output logic             owner,
  output logic             xfer_done,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic             wdog_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_GAP} st_e;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  localparam logic [2:0] SC_LOWPWR = 3'd0;
  localparam logic [2:0] SC_IDLE   = 3'd3;
  localparam logic [2:0] SC_FLUSH  = 3'd4;
  localparam logic [2:0] SC_XFER   = 3'd5;

  st_e              st_q;
  logic             xfer1_q, xfer2_q, owner_q, done_q;
  logic [CNT_W-1:0] cnt_q;
  logic [GAP_W-1:0] gap_q;
  logic             req1_d, req2_d, gnt2_d, wd_fire_d;
  logic [2:0]       gstate_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign req1_d   = (state1 == SC_IDLE) && rdy_xfer1;
  assign req2_d   = (state2 == SC_IDLE) && rdy_xfer2;
  // Scanner2 wins when alone, or on a tie when scanner1 held the link last.
  assign gnt2_d   = req2_d && (!req1_d || !owner_q);
  assign gstate_d = owner_q ? state2 : state1;

`ifdef XSCHED_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

  logic [WD_W-1:0] wd_q;
  logic            werr_q;

  assign wd_fire_d = ((st_q == S_REQ) || (st_q == S_XFER)) && (wd_q == WD_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q   <= '0;
      werr_q <= 1'b0;
    end else begin
      if (((st_q == S_REQ) || (st_q == S_XFER)) && !wd_fire_d) wd_q <= wd_q + 1'b1;
      else                                                     wd_q <= '0;
      if (wd_fire_d) werr_q <= 1'b1;
    end
  end

  assign wdog_err = werr_q;
`else
  assign wd_fire_d = 1'b0;
  assign wdog_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q    <= S_IDLE;
      xfer1_q <= 1'b0;
      xfer2_q <= 1'b0;
      owner_q <= 1'b1;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (st_q)
        S_IDLE: begin
          if (link_en && (req1_d || req2_d)) begin
            st_q    <= S_REQ;
            owner_q <= gnt2_d;
            xfer1_q <= !gnt2_d;
            xfer2_q <= gnt2_d;
          end
        end
        S_REQ: begin
          if (wd_fire_d || (gstate_d == SC_XFER) || (gstate_d == SC_FLUSH) ||
              (gstate_d == SC_LOWPWR)) begin
            xfer1_q <= 1'b0;
            xfer2_q <= 1'b0;
            gap_q   <= '0;
            st_q    <= (!wd_fire_d && (gstate_d == SC_XFER)) ? S_XFER : S_GAP;
          end
        end
        S_XFER: begin
          if (wd_fire_d) begin
            gap_q <= '0;
            st_q  <= S_GAP;
          end else if (gstate_d == SC_LOWPWR) begin
            done_q <= 1'b1;
            cnt_q  <= sat_inc(cnt_q);
            gap_q  <= '0;
            st_q   <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) st_q  <= S_IDLE;
          else                   gap_q <= gap_q + 1'b1;
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end

  assign xfer1     = xfer1_q;
  assign xfer2     = xfer2_q;
  assign busy      = (st_q != S_IDLE);
  assign owner     = owner_q;
  assign xfer_done = done_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_scan_xfer_sched.sv
// Self-checking bench for scan_xfer_sched: randomized transactions against a
// transaction-level model of grantee choice, completion count and gap length.
module tb_scan_xfer_sched;
  localparam int GAP = 4;
`ifdef XSCHED_WDOG_EN
  localparam int WD = 10;
`else
  localparam int WD = 255;
`endif

  logic       clk = 1'b0;
  logic       reset, link_en;
  logic [2:0] state1, state2;
  logic       rdy_xfer1, rdy_xfer2;
  logic       xfer1, xfer2, busy, owner, xfer_done, wdog_err;
  logic [7:0] xfer_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int exp_owner = 1;
  int exp_cnt = 0;

  scan_xfer_sched #(.GAP_CYCLES(GAP), .WDOG_CYCLES(WD), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .link_en(link_en), .state1(state1), .state2(state2),
    .rdy_xfer1(rdy_xfer1), .rdy_xfer2(rdy_xfer2), .xfer1(xfer1), .xfer2(xfer2),
    .busy(busy), .owner(owner), .xfer_done(xfer_done), .xfer_cnt(xfer_cnt),
    .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation time limit reached, checks=%0d", n_chk);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_g(input int who, input logic [2:0] s, input logic r);
    if (who == 0) begin state1 = s; rdy_xfer1 = r; end
    else          begin state2 = s; rdy_xfer2 = r; end
  endtask

  task automatic do_reset();
    state1 = 3'd1; state2 = 3'd1; rdy_xfer1 = 1'b0; rdy_xfer2 = 1'b0; link_en = 1'b1;
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    exp_owner = 1; exp_cnt = 0;
    tick();
  endtask

  // One full grant: outcome 0 = complete, 1 = abort via flushing, 2 = abort via low_pwr.
  task automatic run_xfer(input bit r1, input bit r2, input int outcome, input int hold, input int len);
    int g;
    logic [1:0] want;
    g = (r1 && r2) ? ((exp_owner == 1) ? 0 : 1) : (r2 ? 1 : 0);
    want = (g == 1) ? 2'b10 : 2'b01;
    state1 = r1 ? 3'd3 : 3'd1; rdy_xfer1 = r1;
    state2 = r2 ? 3'd3 : 3'd1; rdy_xfer2 = r2;
    tick();
    exp_owner = g;
    n_chk++;
    if ({xfer2, xfer1} !== want || busy !== 1'b1 || owner !== 1'(g)) begin
      n_fail++;
      $display("FAIL grant: xfer2xfer1=%b busy=%b owner=%b, required xfer2xfer1=%b busy=1 owner=%0d",
               {xfer2, xfer1}, busy, owner, want, g);
    end
    for (int i = 0; i < hold; i++) begin
      set_g(1 - g, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      tick();
      n_chk++;
      if ({xfer2, xfer1} !== want) begin
        n_fail++;
        $display("FAIL req_hold: xfer2xfer1=%b, required %b", {xfer2, xfer1}, want);
      end
    end
    set_g(g, (outcome == 0) ? 3'd5 : ((outcome == 1) ? 3'd4 : 3'd0), 1'b0);
    tick();
    n_chk++;
    if ({xfer2, xfer1} !== 2'b00 || busy !== 1'b1 || xfer_done !== 1'b0 ||
        xfer_cnt !== 8'(exp_cnt)) begin
      n_fail++;
      $display("FAIL req_exit: xfer=%b busy=%b done=%b cnt=%0d, required xfer=00 busy=1 done=0 cnt=%0d",
               {xfer2, xfer1}, busy, xfer_done, xfer_cnt, exp_cnt);
    end
    if (outcome == 0) begin
      for (int i = 0; i < len; i++) begin
        set_g(1 - g, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        tick();
        n_chk++;
        if ({xfer2, xfer1} !== 2'b00 || busy !== 1'b1 || xfer_done !== 1'b0) begin
          n_fail++;
          $display("FAIL xfer_wait: xfer=%b busy=%b done=%b, required 00/1/0",
                   {xfer2, xfer1}, busy, xfer_done);
        end
      end
      set_g(g, 3'd0, 1'b0);
      tick();
      exp_cnt = (exp_cnt >= 255) ? 255 : exp_cnt + 1;
      n_chk++;
      if (xfer_done !== 1'b1 || xfer_cnt !== 8'(exp_cnt) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL done: done=%b cnt=%0d busy=%b, required done=1 cnt=%0d busy=1",
                 xfer_done, xfer_cnt, busy, exp_cnt);
      end
    end
    // The other scanner keeps requesting through the gap; it must not be granted.
    set_g(g, 3'd1, 1'b0);
    set_g(1 - g, 3'd3, 1'b1);
    for (int i = 1; i < GAP; i++) begin
      tick();
      n_chk++;
      if (busy !== 1'b1 || {xfer2, xfer1} !== 2'b00 || xfer_done !== 1'b0) begin
        n_fail++;
        $display("FAIL gap: busy=%b xfer=%b done=%b at gap cycle %0d, required busy=1 xfer=00 done=0",
                 busy, {xfer2, xfer1}, xfer_done, i);
      end
    end
    tick();
    n_chk++;
    if (busy !== 1'b0 || {xfer2, xfer1} !== 2'b00 || xfer_cnt !== 8'(exp_cnt)) begin
      n_fail++;
      $display("FAIL gap_end: busy=%b xfer=%b cnt=%0d, required busy=0 xfer=00 cnt=%0d",
               busy, {xfer2, xfer1}, xfer_cnt, exp_cnt);
    end
    state1 = 3'd1; state2 = 3'd1; rdy_xfer1 = 1'b0; rdy_xfer2 = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({xfer2, xfer1} !== 2'b00 || busy !== 1'b0 || owner !== 1'b1 || xfer_done !== 1'b0 ||
        xfer_cnt !== 8'd0 || wdog_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: xfer=%b busy=%b owner=%b done=%b cnt=%0d wdog=%b, required 00/0/1/0/0/0",
               {xfer2, xfer1}, busy, owner, xfer_done, xfer_cnt, wdog_err);
    end
  endtask

  task automatic test_basic();
    run_xfer(1, 0, 0, 0, 2);
  endtask

  task automatic test_round_robin();
    do_reset();
    run_xfer(1, 1, 0, 0, 1);
    run_xfer(1, 1, 0, 1, 1);
    run_xfer(1, 1, 0, 0, 0);
  endtask

  task automatic test_abort();
    run_xfer(0, 1, 1, 0, 0);
    run_xfer(1, 0, 2, 2, 0);
    run_xfer(0, 1, 2, 1, 0);
  endtask

  task automatic test_link_en();
    link_en = 1'b0; state1 = 3'd3; rdy_xfer1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (xfer1 !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL link_gate: xfer1=%b busy=%b, required 0/0", xfer1, busy);
      end
    end
    link_en = 1'b1;
    tick();
    exp_owner = 0;
    n_chk++;
    if (xfer1 !== 1'b1 || owner !== 1'b0) begin
      n_fail++;
      $display("FAIL link_grant: xfer1=%b owner=%b, required 1/0", xfer1, owner);
    end
    state1 = 3'd5; rdy_xfer1 = 1'b0;
    tick();
    link_en = 1'b0;
    tick(); tick();
    state1 = 3'd0;
    tick();
    exp_cnt = (exp_cnt >= 255) ? 255 : exp_cnt + 1;
    n_chk++;
    if (xfer_done !== 1'b1 || xfer_cnt !== 8'(exp_cnt)) begin
      n_fail++;
      $display("FAIL link_drop_done: done=%b cnt=%0d, required 1/%0d", xfer_done, xfer_cnt, exp_cnt);
    end
    state1 = 3'd1;
    for (int i = 0; i < GAP; i++) tick();
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL link_gap_end: busy=%b, required 0", busy);
    end
    link_en = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int rr;
      rr = $urandom_range(1, 3);
      run_xfer(rr[0], rr[1], $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 4));
    end
  endtask

  task automatic test_async_reset();
    state1 = 3'd3; rdy_xfer1 = 1'b1;
    tick();
    #3 reset = 1'b0;
    #1;
    n_chk++;
    if ({xfer2, xfer1} !== 2'b00 || busy !== 1'b0 || xfer_cnt !== 8'd0 || owner !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: xfer=%b busy=%b cnt=%0d owner=%b, required 00/0/0/1",
               {xfer2, xfer1}, busy, xfer_cnt, owner);
    end
    state1 = 3'd1; rdy_xfer1 = 1'b0;
    tick();
    reset = 1'b1;
    exp_owner = 1; exp_cnt = 0;
    tick();
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 257; n++) run_xfer(1, 0, 0, 0, 0);
    n_chk++;
    if (xfer_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL saturate: cnt=%0d, required 255", xfer_cnt);
    end
  endtask

`ifdef XSCHED_WDOG_EN
  task automatic test_wdog();
    do_reset();
    state1 = 3'd3; rdy_xfer1 = 1'b1;
    tick();
    for (int i = 1; i < WD; i++) begin
      tick();
      n_chk++;
      if (xfer1 !== 1'b1 || wdog_err !== 1'b0) begin
        n_fail++;
        $display("FAIL wdog_hold: cycle %0d xfer1=%b wdog=%b, required 1/0", i, xfer1, wdog_err);
      end
    end
    tick();
    n_chk++;
    if (xfer1 !== 1'b0 || wdog_err !== 1'b1 || xfer_done !== 1'b0 || xfer_cnt !== 8'd0 ||
        busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wdog_fire: xfer1=%b wdog=%b done=%b cnt=%0d busy=%b, required 0/1/0/0/1",
               xfer1, wdog_err, xfer_done, xfer_cnt, busy);
    end
    state1 = 3'd1; rdy_xfer1 = 1'b0;
    for (int i = 0; i < GAP + 2; i++) tick();
    n_chk++;
    if (wdog_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wdog_sticky: wdog=%b busy=%b, required 1/0", wdog_err, busy);
    end
    do_reset();
    n_chk++;
    if (wdog_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wdog_clear: wdog=%b, required 0", wdog_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_abort();
    test_link_en();
    test_random();
    test_async_reset();
    test_saturation();
`ifdef XSCHED_WDOG_EN
    test_wdog();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
